// File: rtl/knn_sorted_list.sv
// K-deep sorted insertion list: keeps the K smallest (distance, label) pairs
// seen since the last clear, ascending by distance, with a registered read port.
module knn_sorted_list #(
    parameter int DATA_W  = 32,
    parameter int LABEL_W = 8,
    parameter int K       = 4,
    localparam int IDX_W  = $clog2(K),
    localparam int CNT_W  = $clog2(K + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               cand_valid,
    output logic               cand_ready,
    input  logic [DATA_W-1:0]  cand_dist,
    input  logic [LABEL_W-1:0] cand_label,
    input  logic               cand_last,
    input  logic [IDX_W-1:0]   rd_idx,
    output logic [DATA_W-1:0]  rd_dist,
    output logic [LABEL_W-1:0] rd_label,
    output logic               rd_vld,
    output logic [CNT_W-1:0]   count,
    output logic [DATA_W-1:0]  worst_dist,
    output logic               done
);

    logic [DATA_W-1:0]  r_dist  [K];
    logic [LABEL_W-1:0] r_label [K];
    logic [K-1:0]       r_vld;
    logic [CNT_W-1:0]   r_count;
    logic               r_last_acc;
    logic               r_done;

    logic [K-1:0]       w_lt;
    logic [DATA_W-1:0]  w_src_dist  [K];
    logic [LABEL_W-1:0] w_src_label [K];
    logic [K-1:0]       w_src_vld;
    logic               w_accept;
    logic               w_insert;

    assign w_accept = cand_valid & ~clr;
    // lt is monotonic, so the last slot having lt set means some slot does.
    assign w_insert = w_accept & w_lt[K-1];

    always_comb begin
        w_lt = '0;
        for (int i = 0; i < K; i++) begin
            w_lt[i] = ~r_vld[i] | (cand_dist < r_dist[i]);
        end
    end

    // A slot whose predecessor also has lt set takes the predecessor's contents;
    // the first lt slot takes the candidate.
    for (genvar g = 0; g < K; g++) begin : g_src
        if (g == 0) begin : g_head
            assign w_src_dist[g]  = cand_dist;
            assign w_src_label[g] = cand_label;
            assign w_src_vld[g]   = 1'b1;
        end else begin : g_body
            assign w_src_dist[g]  = w_lt[g-1] ? r_dist[g-1]  : cand_dist;
            assign w_src_label[g] = w_lt[g-1] ? r_label[g-1] : cand_label;
            assign w_src_vld[g]   = w_lt[g-1] ? r_vld[g-1]   : 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < K; i++) begin
                r_dist[i]  <= '0;
                r_label[i] <= '0;
            end
            r_vld      <= '0;
            r_count    <= '0;
            r_last_acc <= 1'b0;
            r_done     <= 1'b0;
        end else if (clr) begin
            for (int i = 0; i < K; i++) begin
                r_dist[i]  <= '0;
                r_label[i] <= '0;
            end
            r_vld      <= '0;
            r_count    <= '0;
            r_last_acc <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            if (w_insert) begin
                for (int i = 0; i < K; i++) begin
                    if (w_lt[i]) begin
                        r_dist[i]  <= w_src_dist[i];
                        r_label[i] <= w_src_label[i];
                        r_vld[i]   <= w_src_vld[i];
                    end
                end
                if (r_count != CNT_W'(K)) begin
                    r_count <= r_count + CNT_W'(1);
                end
            end
            // done trails the accepting edge by one further edge.
            r_last_acc <= w_accept & cand_last;
            r_done     <= r_last_acc;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_dist  <= '0;
            rd_label <= '0;
            rd_vld   <= 1'b0;
        end else if (32'(rd_idx) < K) begin
            rd_dist  <= r_dist[rd_idx];
            rd_label <= r_label[rd_idx];
            rd_vld   <= r_vld[rd_idx];
        end else begin
            rd_dist  <= '0;
            rd_label <= '0;
            rd_vld   <= 1'b0;
        end
    end

    assign cand_ready = ~clr;
    assign count      = r_count;
    assign done       = r_done;
    assign worst_dist = r_vld[K-1] ? r_dist[K-1] : '1;

endmodule

// File: tb/tb_knn_sorted_list.sv
// Self-checking bench for knn_sorted_list: directed scenarios plus a randomized
// run, compared against a queue-based model of "keep the K smallest, stable".
module tb_knn_sorted_list;

    localparam int DATA_W  = 32;
    localparam int LABEL_W = 8;
    localparam int K       = 4;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               clr = 1'b0;
    logic               cand_valid = 1'b0;
    logic               cand_ready;
    logic [DATA_W-1:0]  cand_dist = '0;
    logic [LABEL_W-1:0] cand_label = '0;
    logic               cand_last = 1'b0;
    logic [1:0]         rd_idx = '0;
    logic [DATA_W-1:0]  rd_dist;
    logic [LABEL_W-1:0] rd_label;
    logic               rd_vld;
    logic [2:0]         count;
    logic [DATA_W-1:0]  worst_dist;
    logic               done;

    int errors = 0;
    int checks = 0;

    logic [DATA_W-1:0]  mDist  [$];
    logic [LABEL_W-1:0] mLabel [$];

    knn_sorted_list #(.DATA_W(DATA_W), .LABEL_W(LABEL_W), .K(K)) dut (
        .clk(clk), .rst(rst), .clr(clr),
        .cand_valid(cand_valid), .cand_ready(cand_ready),
        .cand_dist(cand_dist), .cand_label(cand_label), .cand_last(cand_last),
        .rd_idx(rd_idx), .rd_dist(rd_dist), .rd_label(rd_label), .rd_vld(rd_vld),
        .count(count), .worst_dist(worst_dist), .done(done)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        mDist.delete();
        mLabel.delete();
    endtask

    // Reference: insert before the first strictly larger entry, keep K smallest.
    task automatic model_insert(input logic [DATA_W-1:0] d, input logic [LABEL_W-1:0] l);
        int pos;
        pos = mDist.size();
        for (int i = 0; i < mDist.size(); i++) begin
            if (d < mDist[i]) begin
                pos = i;
                break;
            end
        end
        if (pos < K) begin
            mDist.insert(pos, d);
            mLabel.insert(pos, l);
            if (mDist.size() > K) begin
                void'(mDist.pop_back());
                void'(mLabel.pop_back());
            end
        end
    endtask

    function automatic logic [DATA_W-1:0] model_worst();
        return (mDist.size() == K) ? mDist[K-1] : '1;
    endfunction

    task automatic send(input logic [DATA_W-1:0] d, input logic [LABEL_W-1:0] l, input logic last);
        cand_valid = 1'b1;
        cand_dist  = d;
        cand_label = l;
        cand_last  = last;
        tick();
        cand_valid = 1'b0;
        cand_last  = 1'b0;
        model_insert(d, l);
    endtask

    task automatic do_clear();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        model_clear();
    endtask

    task automatic read_slot(input int idx, output logic [DATA_W-1:0] d,
                             output logic [LABEL_W-1:0] l, output logic v);
        rd_idx = 2'(idx);
        tick();
        d = rd_dist;
        l = rd_label;
        v = rd_vld;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #1;
        checks++; if (count !== 3'd0) begin errors++; $display("[TB] FAIL reset_count: got %0d expected 0", count); end
        checks++; if (worst_dist !== '1) begin errors++; $display("[TB] FAIL reset_worst: got %0h expected ffffffff", worst_dist); end
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %0b expected 0", done); end
        checks++; if (rd_vld !== 1'b0 || rd_dist !== '0 || rd_label !== '0) begin
            errors++; $display("[TB] FAIL reset_rd: got %0h/%0h/%0b expected 0/0/0", rd_dist, rd_label, rd_vld);
        end
        checks++; if (cand_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready: got %0b expected 1", cand_ready); end
        clr = 1'b1;
        #1;
        checks++; if (cand_ready !== 1'b0) begin errors++; $display("[TB] FAIL ready_clr: got %0b expected 0", cand_ready); end
        clr = 1'b0;
        tick();
        rst = 1'b1;
        model_clear();
        tick();
    endtask

    task automatic test_basic();
        logic [DATA_W-1:0] d; logic [LABEL_W-1:0] l; logic v;
        send(32'd10, 8'hA, 1'b0);
        send(32'd5,  8'hB, 1'b0);
        send(32'd7,  8'hC, 1'b0);
        checks++; if (count !== 3'd3) begin errors++; $display("[TB] FAIL basic_count: got %0d expected 3", count); end
        checks++; if (worst_dist !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL basic_worst: got %0h expected ffffffff", worst_dist); end
        read_slot(1, d, l, v);
        checks++; if (d !== 32'd7 || l !== 8'hC || v !== 1'b1) begin
            errors++; $display("[TB] FAIL basic_rd1: got %0d/%0h/%0b expected 7/c/1", d, l, v);
        end
        for (int i = 0; i < K; i++) begin
            read_slot(i, d, l, v);
            checks++;
            if (i < mDist.size()) begin
                if (d !== mDist[i] || l !== mLabel[i] || v !== 1'b1) begin
                    errors++; $display("[TB] FAIL basic_slot%0d: got %0d/%0h/%0b expected %0d/%0h/1", i, d, l, v, mDist[i], mLabel[i]);
                end
            end else if (v !== 1'b0) begin
                errors++; $display("[TB] FAIL basic_slot%0d_vld: got %0b expected 0", i, v);
            end
        end
    endtask

    task automatic test_full();
        logic [DATA_W-1:0] d; logic [LABEL_W-1:0] l; logic v;
        logic [DATA_W-1:0] seq [7];
        seq = '{32'd10, 32'd5, 32'd7, 32'd3, 32'd8, 32'd9, 32'd1};
        do_clear();
        for (int s = 0; s < 7; s++) begin
            send(seq[s], 8'(s + 1), 1'b0);
            checks++; if (count !== 3'(mDist.size())) begin errors++; $display("[TB] FAIL full_count%0d: got %0d expected %0d", s, count, mDist.size()); end
            checks++; if (worst_dist !== model_worst()) begin errors++; $display("[TB] FAIL full_worst%0d: got %0h expected %0h", s, worst_dist, model_worst()); end
            if (s >= 4) begin
                for (int i = 0; i < K; i++) begin
                    read_slot(i, d, l, v);
                    checks++;
                    if (d !== mDist[i] || l !== mLabel[i] || v !== 1'b1) begin
                        errors++; $display("[TB] FAIL full%0d_slot%0d: got %0d/%0h/%0b expected %0d/%0h/1", s, i, d, l, v, mDist[i], mLabel[i]);
                    end
                end
            end
        end
    endtask

    task automatic test_ties();
        logic [DATA_W-1:0] d; logic [LABEL_W-1:0] l; logic v;
        do_clear();
        send(32'd5, 8'hA, 1'b0);
        send(32'd5, 8'hB, 1'b0);
        read_slot(0, d, l, v);
        checks++; if (l !== 8'hA || d !== 32'd5) begin errors++; $display("[TB] FAIL tie_slot0: got %0d/%0h expected 5/a", d, l); end
        read_slot(1, d, l, v);
        checks++; if (l !== 8'hB || d !== 32'd5) begin errors++; $display("[TB] FAIL tie_slot1: got %0d/%0h expected 5/b", d, l); end
        do_clear();
        send(32'd2, 8'h1, 1'b0);
        send(32'd5, 8'hA, 1'b0);
        send(32'd5, 8'hB, 1'b0);
        send(32'd5, 8'hC, 1'b0);
        send(32'd5, 8'hD, 1'b0);
        checks++; if (count !== 3'd4 || worst_dist !== 32'd5) begin
            errors++; $display("[TB] FAIL tie_full: got count %0d worst %0d expected 4/5", count, worst_dist);
        end
        for (int i = 0; i < K; i++) begin
            read_slot(i, d, l, v);
            checks++;
            if (d !== mDist[i] || l !== mLabel[i] || v !== 1'b1) begin
                errors++; $display("[TB] FAIL tie_slot%0d: got %0d/%0h/%0b expected %0d/%0h/1", i, d, l, v, mDist[i], mLabel[i]);
            end
        end
    endtask

    task automatic test_clr_collision();
        logic [DATA_W-1:0] d; logic [LABEL_W-1:0] l; logic v;
        clr = 1'b1;
        cand_valid = 1'b1;
        cand_dist = 32'd1;
        cand_label = 8'hEE;
        #1;
        checks++; if (cand_ready !== 1'b0) begin errors++; $display("[TB] FAIL clr_ready: got %0b expected 0", cand_ready); end
        tick();
        clr = 1'b0;
        cand_valid = 1'b0;
        model_clear();
        checks++; if (count !== 3'd0) begin errors++; $display("[TB] FAIL clr_count: got %0d expected 0", count); end
        checks++; if (worst_dist !== '1) begin errors++; $display("[TB] FAIL clr_worst: got %0h expected ffffffff", worst_dist); end
        for (int i = 0; i < K; i++) begin
            read_slot(i, d, l, v);
            checks++; if (v !== 1'b0) begin errors++; $display("[TB] FAIL clr_slot%0d_vld: got %0b expected 0", i, v); end
        end
    endtask

    task automatic test_done();
        do_clear();
        send(32'd20, 8'h1, 1'b1);
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL done_ins_early: got %0b expected 0", done); end
        tick();
        checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL done_ins_pulse: got %0b expected 1", done); end
        tick();
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL done_ins_late: got %0b expected 0", done); end
        send(32'd1, 8'h2, 1'b0);
        send(32'd2, 8'h3, 1'b0);
        send(32'd3, 8'h4, 1'b0);
        send(32'd50, 8'h5, 1'b1);
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL done_rej_early: got %0b expected 0", done); end
        tick();
        checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL done_rej_pulse: got %0b expected 1", done); end
        tick();
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL done_rej_late: got %0b expected 0", done); end
        checks++; if (count !== 3'd4 || worst_dist !== 32'd20) begin
            errors++; $display("[TB] FAIL done_rej_list: got count %0d worst %0d expected 4/20", count, worst_dist);
        end
    endtask

    task automatic test_back_to_back_reset();
        logic [DATA_W-1:0] d; logic [LABEL_W-1:0] l; logic v;
        do_clear();
        send(32'd30, 8'h7, 1'b1);
        cand_valid = 1'b1;
        cand_dist = 32'd40;
        cand_label = 8'h8;
        rst = 1'b0;
        #1;
        model_clear();
        checks++; if (count !== 3'd0 || done !== 1'b0 || rd_vld !== 1'b0 || worst_dist !== '1) begin
            errors++; $display("[TB] FAIL rst_mid: got count %0d done %0b rd_vld %0b worst %0h expected 0/0/0/ffffffff", count, done, rd_vld, worst_dist);
        end
        tick();
        rst = 1'b1;
        tick();
        cand_valid = 1'b0;
        model_insert(32'd40, 8'h8);
        checks++; if (count !== 3'd1) begin errors++; $display("[TB] FAIL rst_after_count: got %0d expected 1", count); end
        read_slot(0, d, l, v);
        checks++; if (d !== 32'd40 || l !== 8'h8 || v !== 1'b1) begin
            errors++; $display("[TB] FAIL rst_after_slot0: got %0d/%0h/%0b expected 40/8/1", d, l, v);
        end
        read_slot(1, d, l, v);
        checks++; if (v !== 1'b0) begin errors++; $display("[TB] FAIL rst_after_slot1: got %0b expected 0", v); end
    endtask

    task automatic test_random();
        logic [DATA_W-1:0] d; logic [LABEL_W-1:0] l; logic v;
        logic doClr, doValid, doLast, pendLast, expDone;
        do_clear();
        pendLast = 1'b0;
        for (int n = 0; n < 400; n++) begin
            doClr   = ($urandom_range(0, 40) == 0);
            doValid = ($urandom_range(0, 3) != 0);
            doLast  = ($urandom_range(0, 7) == 0);
            d = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFF : 32'($urandom_range(0, 20));
            l = 8'($urandom);
            clr = doClr;
            cand_valid = doValid;
            cand_dist = d;
            cand_label = l;
            cand_last = doLast;
            #1;
            checks++; if (cand_ready !== !doClr) begin errors++; $display("[TB] FAIL rnd_ready%0d: got %0b expected %0b", n, cand_ready, !doClr); end
            tick();
            if (doClr) begin
                model_clear();
                expDone = 1'b0;
                pendLast = 1'b0;
            end else begin
                expDone = pendLast;
                pendLast = doValid & doLast;
                if (doValid) model_insert(d, l);
            end
            checks++; if (count !== 3'(mDist.size())) begin errors++; $display("[TB] FAIL rnd_count%0d: got %0d expected %0d", n, count, mDist.size()); end
            checks++; if (worst_dist !== model_worst()) begin errors++; $display("[TB] FAIL rnd_worst%0d: got %0h expected %0h", n, worst_dist, model_worst()); end
            checks++; if (done !== expDone) begin errors++; $display("[TB] FAIL rnd_done%0d: got %0b expected %0b", n, done, expDone); end
        end
        clr = 1'b0;
        cand_valid = 1'b0;
        cand_last = 1'b0;
        for (int i = 0; i < K; i++) begin
            read_slot(i, d, l, v);
            checks++;
            if (i < mDist.size()) begin
                if (d !== mDist[i] || l !== mLabel[i] || v !== 1'b1) begin
                    errors++; $display("[TB] FAIL rnd_slot%0d: got %0h/%0h/%0b expected %0h/%0h/1", i, d, l, v, mDist[i], mLabel[i]);
                end
            end else if (v !== 1'b0) begin
                errors++; $display("[TB] FAIL rnd_slot%0d_vld: got %0b expected 0", i, v);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full();
        test_ties();
        test_clr_collision();
        test_done();
        test_back_to_back_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/knn_sorted_list.md
# knn_sorted_list

Parametrised K-deep sorted insertion list for the KNN accelerator: a systolic chain of K slots that keeps the K smallest (distance, label) pairs seen since the last clear, ascending by distance. It sits after the distance unit and feeds the label-vote stage through a registered read port. It adds per-slot occupancy, a ready/valid candidate handshake, synchronous clear, a frame-done pulse and a worst-distance output.

## Interface
- DATA_W, 32, distance width (unsigned)
- LABEL_W, 8, label width
- K, 4, list depth; legal range 2..64
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- clr  in  1  synchronous list clear (start of new query)
- cand_valid  in  1  candidate present
- cand_ready  out  1  candidate accepted when cand_valid & cand_ready
- cand_dist  in  DATA_W  candidate distance
- cand_label  in  LABEL_W  candidate label
- cand_last  in  1  marks final candidate of a query
- rd_idx  in  $clog2(K)  slot to read (0 = nearest)
- rd_dist  out  DATA_W  registered slot distance
- rd_label  out  LABEL_W  registered slot label
- rd_vld  out  1  registered slot occupancy
- count  out  $clog2(K+1)  occupied slots, saturates at K
- worst_dist  out  DATA_W  distance in slot K-1 when full, else all ones
- done  out  1  one-cycle pulse after the last candidate is processed

## Operation
- State: per slot i: dist[i], label[i], vld[i]; occupied slots always packed at indices 0..count-1, ascending, non-decreasing distance.
- Per-slot compare: lt[i] = ~vld[i] | (cand_dist < dist[i]) (strict). lt is monotonic 0..0,1..1 across i.
- On accepted candidate, slot i: if lt[i] & (i==0 | ~lt[i-1]) load candidate; else if lt[i] load slot i-1 (dist, label, vld); else hold. Slot K-1 contents shifted out are discarded.
- No slot has lt set (list full, cand_dist >= dist[K-1]) -> candidate discarded, list unchanged, count unchanged.
- Ties: strict compare, so a new equal-distance candidate lands after existing equals (stable, first-come wins); a full list with worst == cand_dist rejects it.
- count increments by 1 on an inserting accept while count < K; otherwise holds.
- cand_ready = ~clr (no backpressure otherwise; one candidate per cycle).
- clr: all vld <= 0, count <= 0, done <= 0; dist/label values are don't-care but reset to 0 for determinism. clr wins over a same-cycle candidate (candidate not accepted, ready low).
- done: set for exactly one cycle on the edge after the edge that accepts a candidate with cand_last=1, whether inserted or discarded.
- Read port: rd_dist/rd_label/rd_vld <= slot[rd_idx] each cycle; rd_idx >= K (non-power-of-2 K) returns zeros with rd_vld=0.
- Arithmetic: unsigned compare over full DATA_W; all-ones distance is a valid value and is stored if the slot is empty.

## Timing
- Reset (rst low, async): all vld, dist, label, count, done, rd_dist, rd_label, rd_vld = 0; worst_dist = all ones; cand_ready follows clr combinationally.
- Insertion: candidate accepted at edge N is visible in slots/count/worst_dist after edge N; read port reflects it after edge N+1 (1-cycle read latency).
- Back-to-back candidates every cycle supported; each compares against the list state updated by the previous one.
- worst_dist is combinational from slot K-1 and vld[K-1].
- rst asserted mid-insertion: state cleared immediately, no partial shift; first accept after release compares against an empty list.

## Test plan
- Reset then insert (10,A),(5,B),(7,C) -> slots [5B,7C,10A], count=3, worst_dist=FFFFFFFF, read idx1 returns 7/C/vld=1 one cycle after rd_idx set.
- K=4, insert 10,5,7,3,8 -> [3,5,7,8], count=4, worst_dist=8; then insert 9 -> unchanged; insert 1 -> [1,3,5,7].
- Ties: insert (5,A),(5,B) -> slot0 A, slot1 B; fill to [2,5,5,5], insert (5,D) -> rejected, list unchanged.
- clr and cand_valid with (1,X) same cycle -> cand_ready=0, count=0 next cycle, all rd_vld=0, no insertion.
- cand_last on an inserted candidate and on a rejected candidate -> done high exactly one cycle after each accept edge, low otherwise.
- Drop rst for one cycle between two back-to-back accepts -> all outputs at reset values immediately; following accept yields count=1, slot0 = that candidate.
